// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - tick-driven countdown timer with optional auto-reload
module countdown_timer #(
  parameter int WIDTH       = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             run,
  output logic             expired,
  output logic             expire_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick_dly_q, tick_dly_d;
  logic             run_q, run_d;
  logic             expired_q, expired_d;
  logic             expire_pulse_q, expire_pulse_d;
  logic             tick_rise;

  // Rising-edge detect; the delayed copy tracks tick in every state so a level
  // held across a pause/resume is never counted twice.
  assign tick_rise = tick & ~tick_dly_q;

  // Next-state logic with priority load > stop > start > tick_rise.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    reload_d       = reload_q;
    tick_dly_d     = tick;
    expire_pulse_d = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && start && (count_q != '0)) begin
            state_d = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (stop) begin
            // A tick landing on the same cycle as stop is dropped.
            state_d = ST_PAUSED;
          end else if (tick_rise) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              expire_pulse_d = 1'b1;
              if (AUTO_RELOAD) begin
                if (reload_q != '0) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = ST_IDLE;
                end
              end else begin
                count_d = '0;
                state_d = ST_EXPIRED;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (!stop && start) begin
            state_d = ST_RUNNING;
          end
        end
        ST_EXPIRED: begin
          count_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    run_d     = (state_d == ST_RUNNING);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State and registered outputs; rst overrides everything, including a pending expiry pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      reload_q       <= '0;
      tick_dly_q     <= 1'b0;
      run_q          <= 1'b0;
      expired_q      <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      reload_q       <= reload_d;
      tick_dly_q     <= tick_dly_d;
      run_q          <= run_d;
      expired_q      <= expired_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign count        = count_q;
  assign run          = run_q;
  assign expired      = expired_q;
  assign expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;

  logic         a_tick, a_load, a_start, a_stop;
  logic [W-1:0] a_load_value;
  logic [W-1:0] a_count;
  logic         a_run, a_expired, a_expire_pulse;

  logic         b_tick, b_load, b_start, b_stop;
  logic [W-1:0] b_load_value;
  logic [W-1:0] b_count;
  logic         b_run, b_expired, b_expire_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tick(a_tick), .load(a_load), .load_value(a_load_value),
    .start(a_start), .stop(a_stop), .count(a_count), .run(a_run),
    .expired(a_expired), .expire_pulse(a_expire_pulse)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .tick(b_tick), .load(b_load), .load_value(b_load_value),
    .start(b_start), .stop(b_stop), .count(b_count), .run(b_run),
    .expired(b_expired), .expire_pulse(b_expire_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_start(input logic [W-1:0] v);
    a_load_value = v; a_load = 1'b1; step(); a_load = 1'b0;
    a_start = 1'b1; step(); a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_tick = ~a_tick;
      step();
      tests_run++;
      if (a_count !== 16'd0 || a_run !== 1'b0 || a_expired !== 1'b0 || a_expire_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs: count=%0d run=%0b expired=%0b pulse=%0b, want 0 0 0 0",
                 a_count, a_run, a_expired, a_expire_pulse);
      end
    end
    rst = 1'b0; a_tick = 1'b0;
    step();
    a_start = 1'b1; step(); a_start = 1'b0; step();
    tests_run++;
    if (a_run !== 1'b0 || a_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL start_zero_count: run=%0b count=%0d, want run=0 count=0", a_run, a_count);
    end
  endtask

  task automatic test_basic_countdown();
    logic [W-1:0] exp_cnt;
    a_load_value = 16'd3; a_load = 1'b1; step(); a_load = 1'b0;
    tests_run++;
    if (a_count !== 16'd3 || a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL load3: count=%0d run=%0b, want 3 0", a_count, a_run);
    end
    a_start = 1'b1; step(); a_start = 1'b0;
    tests_run++;
    if (a_run !== 1'b1 || a_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL start3: run=%0b count=%0d, want 1 3", a_run, a_count);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (9) step();
      a_tick = 1'b1; step();
      exp_cnt = W'(2 - i);
      tests_run++;
      if (a_count !== exp_cnt || a_expire_pulse !== (i == 2)) begin
        tests_failed++;
        $display("FAIL countdown_tick%0d: count=%0d pulse=%0b, want %0d %0b",
                 i, a_count, a_expire_pulse, exp_cnt, (i == 2));
      end
      a_tick = 1'b0; step();
      tests_run++;
      if (a_expire_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL pulse_width%0d: pulse=%0b, want 0", i, a_expire_pulse);
      end
    end
    tests_run++;
    if (a_expired !== 1'b1 || a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL expired_level: expired=%0b run=%0b, want 1 0", a_expired, a_run);
    end
    a_tick = 1'b1; a_start = 1'b1; step(); a_tick = 1'b0; a_start = 1'b0; step();
    tests_run++;
    if (a_count !== 16'd0 || a_expired !== 1'b1 || a_run !== 1'b0 || a_expire_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL expired_hold: count=%0d expired=%0b run=%0b pulse=%0b, want 0 1 0 0",
               a_count, a_expired, a_run, a_expire_pulse);
    end
  endtask

  task automatic test_held_tick();
    a_load_start(16'd5);
    a_tick = 1'b1; step();
    tests_run++;
    if (a_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL held_first: count=%0d, want 4", a_count);
    end
    repeat (49) step();
    tests_run++;
    if (a_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL held_level: count=%0d, want 4", a_count);
    end
    a_tick = 1'b0; a_stop = 1'b1; step(); a_stop = 1'b0;
    repeat (2) begin
      a_tick = 1'b1; step(); a_tick = 1'b0; step();
    end
    tests_run++;
    if (a_count !== 16'd4 || a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL paused_ticks: count=%0d run=%0b, want 4 0", a_count, a_run);
    end
    a_start = 1'b1; step(); a_start = 1'b0;
    a_tick = 1'b1; step(); a_tick = 1'b0;
    tests_run++;
    if (a_count !== 16'd3 || a_run !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume_tick: count=%0d run=%0b, want 3 1", a_count, a_run);
    end
  endtask

  task automatic test_stop_tick_same_cycle();
    step();
    a_tick = 1'b1; step(); a_tick = 1'b0; step();
    tests_run++;
    if (a_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL pre_stop: count=%0d, want 2", a_count);
    end
    a_stop = 1'b1; a_tick = 1'b1; step(); a_stop = 1'b0; a_tick = 1'b0; step();
    tests_run++;
    if (a_count !== 16'd2 || a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_and_tick: count=%0d run=%0b, want 2 0", a_count, a_run);
    end
  endtask

  task automatic test_load_start_expired();
    a_load_start(16'd1);
    a_tick = 1'b1; step(); a_tick = 1'b0; step();
    tests_run++;
    if (a_expired !== 1'b1 || a_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reach_expired: expired=%0b count=%0d, want 1 0", a_expired, a_count);
    end
    a_load_value = 16'd7; a_load = 1'b1; a_start = 1'b1; step();
    a_load = 1'b0; a_start = 1'b0;
    tests_run++;
    if (a_count !== 16'd7 || a_run !== 1'b0 || a_expired !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_over_start: count=%0d run=%0b expired=%0b, want 7 0 0",
               a_count, a_run, a_expired);
    end
    step();
    tests_run++;
    if (a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_stays_idle: run=%0b, want 0", a_run);
    end
  endtask

  task automatic test_mid_reset();
    a_load_start(16'd1);
    a_tick = 1'b1; rst = 1'b1; step(); rst = 1'b0; a_tick = 1'b0;
    tests_run++;
    if (a_count !== 16'd0 || a_expire_pulse !== 1'b0 || a_run !== 1'b0 || a_expired !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: count=%0d pulse=%0b run=%0b expired=%0b, want 0 0 0 0",
               a_count, a_expire_pulse, a_run, a_expired);
    end
    step();
    tests_run++;
    if (a_expire_pulse !== 1'b0 || a_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_after: pulse=%0b count=%0d, want 0 0", a_expire_pulse, a_count);
    end
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_seq [6];
    int pulses;
    exp_seq = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2};
    pulses = 0;
    b_load_value = 16'd2; b_load = 1'b1; step(); b_load = 1'b0;
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_tick = 1'b1; step(); b_tick = 1'b0;
      if (b_expire_pulse === 1'b1) pulses++;
      tests_run++;
      if (b_count !== exp_seq[i] || b_run !== 1'b1) begin
        tests_failed++;
        $display("FAIL reload_tick%0d: count=%0d run=%0b, want %0d 1", i, b_count, b_run, exp_seq[i]);
      end
      repeat (3) begin
        step();
        if (b_expire_pulse === 1'b1) pulses++;
      end
    end
    tests_run++;
    if (pulses != 3 || b_expired !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_pulses: pulses=%0d expired=%0b, want 3 0", pulses, b_expired);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_tick = 1'b0; a_load = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_load_value = '0;
    b_tick = 1'b0; b_load = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_load_value = '0;
    test_reset();
    test_basic_countdown();
    test_held_tick();
    test_stop_tick_same_cycle();
    test_load_start_expired();
    test_mid_reset();
    test_auto_reload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Seconds-granularity countdown timer that consumes the one-per-period tick pulse produced by the Hz clock divider.
- Holds a loadable count and decrements once per tick while running.
- Flags expiry as both a level and a single-cycle pulse.
- Drives a run output intended for the divider's enable input, so the tick source only advances while the timer runs.
- Optional auto-reload turns it into a periodic N-tick event generator for LED/test sequencing.

Parameters:
- WIDTH, 16: width of count, load_value and the internal reload register.
- AUTO_RELOAD, 0:
  - 0: timer stops in EXPIRED when the count reaches zero.
  - 1: timer reloads the last loaded value and keeps running.

Ports:
- clk  input  1  system clock (12 MHz board clock).
- rst  input  1  reset, synchronous and active-high.
- tick  input  1  tick from the Hz divider. Only 0->1 transitions are counted, so a held-high level counts once.
- load  input  1  capture load_value into count and the reload register; force IDLE.
- load_value  input  WIDTH  value captured on load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- count  output  WIDTH  current remaining ticks (registered).
- run  output  1  high while in RUNNING (registered). Intended for the divider enable.
- expired  output  1  level, high while in EXPIRED (AUTO_RELOAD=0 only).
- expire_pulse  output  1  one-clk pulse on each expiry event.

Behaviour:
- One clock domain; all outputs registered; no combinational input-to-output paths.
- Reset (rst=1 at a clk edge):
  - state=IDLE; count=0; reload=0; tick_d=0; run=0; expired=0; expire_pulse=0.
  - rst overrides every other input.
- Edge detect:
  - tick_d <= tick every cycle in every state.
  - tick_rise = tick & ~tick_d.
  - Because tick_d tracks tick during IDLE/PAUSED, a tick held high across resume is not counted again.
- States: IDLE, RUNNING, PAUSED, EXPIRED. run = (state==RUNNING); expired = (state==EXPIRED).
- Priority in each cycle: rst > load > stop > start > tick_rise.
- load, in any state: count<=load_value; reload<=load_value; state<=IDLE; expire_pulse<=0.
- IDLE:
  - start with count!=0 -> RUNNING.
  - start with count==0 is ignored and the block stays IDLE.
  - tick is ignored.
- RUNNING:
  - stop -> PAUSED. A tick_rise in the same cycle is discarded.
  - tick_rise with count>1: count<=count-1.
  - tick_rise with count==1: count<=0; expire_pulse<=1 on the next cycle. Then:
    - AUTO_RELOAD=0: state<=EXPIRED.
    - AUTO_RELOAD=1: count<=reload, state stays RUNNING, but only if reload!=0. If reload==0: count<=0 and state<=IDLE.
  - start while RUNNING is a no-op.
- PAUSED:
  - start -> RUNNING; count is unchanged.
  - tick is ignored.
  - stop is a no-op.
- EXPIRED:
  - count holds 0.
  - start and stop are ignored.
  - Only load or rst exits.
- Latency:
  - count changes on the clk edge following the cycle where tick_rise is true.
  - run, expired and expire_pulse change on that same edge.
- expire_pulse is exactly one clk cycle wide and is 0 in every other cycle.
- Arithmetic: count never wraps. count==0 is never decremented; reaching RUNNING requires count!=0.
- Mid-operation reset: rst during RUNNING clears everything to reset values on that edge. An in-flight expiry pulse is suppressed.

Test Plan:
- rst=1 for 2 cycles, tick toggling -> count=0, run=0, expired=0, expire_pulse=0 throughout. start then gives no RUNNING (count==0).
- load_value=3, load, start, three 1-cycle ticks 10 cycles apart -> count 3,2,1,0:
  - each update one cycle after its tick;
  - one expire_pulse cycle;
  - expired=1, run=0 held.
  - Further ticks and start leave count=0.
- load 5, start, tick held high 50 cycles -> count=4 only. stop; pulse tick twice -> count stays 4, run=0. start, one tick -> count=3.
- Same cycle: stop and tick_rise while RUNNING with count=2 -> PAUSED, count stays 2.
- Same cycle: load=7 and start while EXPIRED -> IDLE, count=7, run=0, expired=0.
- AUTO_RELOAD=1, load 2, start, 6 ticks -> count 1,0->2 (reload),1,2,1,2; expire_pulse exactly 3 times; run stays 1.
- Separately, rst asserted the cycle count goes 1->0 -> no expire_pulse.
